// File: rtl/im_boot_loader_if.sv
// Byte-stream and instruction-memory write bundle for the boot loader.
// The loader takes the slave view; the UART/memory side takes the master view.
interface im_boot_loader_if #(
    parameter int ADDR_W = 16
);
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              reload;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;

    modport master (
        output rx_valid, rx_data, reload,
        input  im_we, im_addr, im_wdata
    );

    modport slave (
        input  rx_valid, rx_data, reload,
        output im_we, im_addr, im_wdata
    );
endinterface

// File: rtl/im_boot_loader.sv
// Loads instruction memory from a UART byte frame (N, 4*N little-endian bytes,
// XOR checksum) and holds the core in reset until a verified program is present.
module im_boot_loader #(
    parameter int ADDR_W    = 16,
    parameter int MAX_WORDS = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    im_boot_loader_if.slave bus,
    output logic            cpu_rst_n,
    output logic            busy,
    output logic            err
);

    typedef enum logic [2:0] {
        S_LEN,
        S_DATA,
        S_CHK,
        S_RUN,
        S_ERR
    } state_t;

    localparam logic [7:0] MAX_N = 8'(MAX_WORDS);

    state_t state, state_d;

    logic [6:0]        index, index_d;
    logic [6:0]        n_words, n_words_d;
    logic [1:0]        byte_cnt, byte_cnt_d;
    logic [7:0]        acc, acc_d;
    logic [23:0]       partial, partial_d;

    logic              im_we_q, im_we_d;
    logic [ADDR_W-1:0] im_addr_q, im_addr_d;
    logic [31:0]       im_wdata_q, im_wdata_d;
    logic              cpu_rst_n_q, busy_q, err_q;

    // NOTE: registers use non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_LEN;
        end else begin
            state <= state_d;
        end
    end

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        state_d    = state;
        index_d    = index;
        n_words_d  = n_words;
        byte_cnt_d = byte_cnt;
        acc_d      = acc;
        partial_d  = partial;
        im_we_d    = 1'b0;
        im_addr_d  = im_addr_q;
        im_wdata_d = im_wdata_q;

        // reload wins over a simultaneous byte, which is simply dropped
        if (bus.reload) begin
            state_d    = S_LEN;
            index_d    = '0;
            byte_cnt_d = '0;
            acc_d      = '0;
            partial_d  = '0;
        end else if (bus.rx_valid) begin
            case (state)
                S_LEN: begin
                    if (bus.rx_data == 8'd0 || bus.rx_data > MAX_N) begin
                        state_d = S_ERR;
                    end else begin
                        n_words_d  = bus.rx_data[6:0];
                        index_d    = '0;
                        byte_cnt_d = '0;
                        acc_d      = '0;
                        partial_d  = '0;
                        state_d    = S_DATA;
                    end
                end

                S_DATA: begin
                    acc_d      = acc ^ bus.rx_data;
                    byte_cnt_d = byte_cnt + 2'd1;
                    case (byte_cnt)
                        2'd0: partial_d[7:0]   = bus.rx_data;
                        2'd1: partial_d[15:8]  = bus.rx_data;
                        2'd2: partial_d[23:16] = bus.rx_data;
                        default: begin
                            im_we_d    = 1'b1;
                            im_addr_d  = ADDR_W'({index, 2'b00});
                            im_wdata_d = {bus.rx_data, partial};
                            index_d    = index + 7'd1;
                            if (index == n_words - 7'd1) begin
                                state_d = S_CHK;
                            end
                        end
                    endcase
                end

                S_CHK: begin
                    state_d = (bus.rx_data == acc) ? S_RUN : S_ERR;
                end

                // RUN and ERR ignore the byte stream
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            index       <= '0;
            n_words     <= '0;
            byte_cnt    <= '0;
            acc         <= '0;
            partial     <= '0;
            im_we_q     <= 1'b0;
            im_addr_q   <= '0;
            im_wdata_q  <= '0;
            cpu_rst_n_q <= 1'b0;
            busy_q      <= 1'b1;
            err_q       <= 1'b0;
        end else begin
            index       <= index_d;
            n_words     <= n_words_d;
            byte_cnt    <= byte_cnt_d;
            acc         <= acc_d;
            partial     <= partial_d;
            im_we_q     <= im_we_d;
            im_addr_q   <= im_addr_d;
            im_wdata_q  <= im_wdata_d;
            cpu_rst_n_q <= (state_d == S_RUN);
            busy_q      <= (state_d == S_LEN) || (state_d == S_DATA) || (state_d == S_CHK);
            err_q       <= (state_d == S_ERR);
        end
    end

    assign bus.im_we    = im_we_q;
    assign bus.im_addr  = im_addr_q;
    assign bus.im_wdata = im_wdata_q;
    assign cpu_rst_n    = cpu_rst_n_q;
    assign busy         = busy_q;
    assign err          = err_q;

endmodule

// File: tb/tb_im_boot_loader.sv
// Self-checking bench for im_boot_loader: frame-level reference model, random
// frames and gaps, plus directed boundary, reload and async-reset scenarios.
module tb_im_boot_loader;

    localparam int ADDR_W    = 16;
    localparam int MAX_WORDS = 64;

    logic clk = 1'b0;
    logic rst_n;
    logic cpu_rst_n, busy, err;

    im_boot_loader_if #(.ADDR_W(ADDR_W)) bus ();

    im_boot_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .cpu_rst_n (cpu_rst_n),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] frm[$];
    int         cyc    = 0;
    int         checks = 0;
    int         errors = 0;
    bit         exp_run, exp_err;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    // Every write strobe must match the oldest expected write, including its cycle.
    always @(negedge clk) begin
        wr_t w;
        if (rst_n === 1'b1 && bus.im_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious_we", 32'(bus.im_we), 32'd0);
            end else begin
                w = exp_q.pop_front();
                check("we_addr", 32'(bus.im_addr), w.addr);
                check("we_data", bus.im_wdata, w.data);
                check("we_cycle", cyc, w.cyc);
            end
        end
    end

    task automatic check_outputs(input string tag);
        check({tag, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'(exp_run));
        check({tag, "_err"}, 32'(err), 32'(exp_err));
        check({tag, "_busy"}, 32'(busy), 32'(!exp_run && !exp_err));
    endtask

    // Drives frm from LEN; the model derives writes and outcome from the frame rules.
    task automatic send_frame(input string tag, input int gap_max);
        int         n;
        bit         ok;
        logic [7:0] x;
        n  = (frm.size() > 0) ? int'(frm[0]) : 0;
        ok = (n >= 1) && (n <= MAX_WORDS);
        x  = 8'd0;
        for (int k = 0; k < frm.size(); k++) begin
            bus.rx_valid = 1'b1;
            bus.rx_data  = frm[k];
            if (ok && k >= 4 && k <= 4 * n && (k % 4) == 0)
                exp_q.push_back('{addr: 32'(k - 4),
                                  data: {frm[k], frm[k-1], frm[k-2], frm[k-3]},
                                  cyc:  cyc + 1});
            @(negedge clk);
            if (gap_max > 0) begin
                repeat ($urandom_range(gap_max, 0)) begin
                    bus.rx_valid = 1'b0;
                    @(negedge clk);
                end
            end
        end
        bus.rx_valid = 1'b0;
        #1;
        exp_run = 1'b0;
        exp_err = (frm.size() > 0) && !ok;
        if (ok && frm.size() >= 4 * n + 2) begin
            for (int k = 1; k <= 4 * n; k++) x ^= frm[k];
            if (x == frm[4*n+1]) exp_run = 1'b1;
            else                 exp_err = 1'b1;
        end
        check({tag, "_missing_we"}, exp_q.size(), 0);
        check_outputs(tag);
    endtask

    task automatic send_junk(input string tag, input int count);
        for (int k = 0; k < count; k++) begin
            bus.rx_valid = 1'b1;
            bus.rx_data  = 8'($urandom);
            @(negedge clk);
        end
        bus.rx_valid = 1'b0;
        #1;
        check_outputs(tag);
    endtask

    task automatic do_reload(input bit with_byte, input logic [7:0] b);
        bus.reload   = 1'b1;
        bus.rx_valid = with_byte;
        bus.rx_data  = b;
        @(negedge clk);
        bus.reload   = 1'b0;
        bus.rx_valid = 1'b0;
        #1;
        exp_run = 1'b0;
        exp_err = 1'b0;
        check_outputs("reload");
    endtask

    task automatic build_frame(input int n, input bit good);
        logic [7:0] x, b;
        x = 8'd0;
        frm.delete();
        frm.push_back(8'(n));
        for (int i = 0; i < 4 * n; i++) begin
            b = 8'($urandom);
            x ^= b;
            frm.push_back(b);
        end
        frm.push_back(good ? x : (x ^ 8'($urandom_range(255, 1))));
    endtask

    task automatic load_nominal(input logic [7:0] chk);
        frm = '{8'h02, 8'h93, 8'h05, 8'h00, 8'h40, 8'h93, 8'h85, 8'h05, 8'h40, chk};
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, got time %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'd0;
        bus.reload   = 1'b0;
        rst_n        = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_im_we", 32'(bus.im_we), 32'd0);
        check("rst_im_addr", 32'(bus.im_addr), 32'd0);
        check("rst_im_wdata", bus.im_wdata, 32'd0);
        exp_run = 1'b0;
        exp_err = 1'b0;
        check_outputs("rst");
        rst_n = 1'b1;
        @(negedge clk);
        check_outputs("idle");

        // Nominal load, then the stream belongs to the core
        load_nominal(8'h85);
        send_frame("nominal", 0);
        send_junk("run_ignores_rx", 8);

        // Bad lengths
        do_reload(1'b0, 8'h00);
        frm = '{8'h00};
        send_frame("len_zero", 0);
        send_junk("err_ignores_rx", 4);
        do_reload(1'b0, 8'h00);
        frm = '{8'h41};
        send_frame("len_65", 0);

        // Bad checksum, then recover via reload
        do_reload(1'b0, 8'h00);
        load_nominal(8'h84);
        send_frame("bad_chk", 0);
        do_reload(1'b0, 8'h00);
        load_nominal(8'h85);
        send_frame("after_bad_chk", 1);

        // Reload mid-word, and reload colliding with a byte
        do_reload(1'b0, 8'h00);
        frm = '{8'h02, 8'h93, 8'h05};
        send_frame("partial", 0);
        do_reload(1'b1, 8'h01);
        load_nominal(8'h85);
        send_frame("after_partial", 0);

        // Full-size program streamed back to back
        do_reload(1'b0, 8'h00);
        build_frame(MAX_WORDS, 1'b1);
        send_frame("max_words", 0);

        // Random frames, lengths, gaps and checksums
        for (int t = 0; t < 24; t++) begin
            do_reload(1'b0, 8'h00);
            if ($urandom_range(5, 0) == 0) begin
                n = ($urandom_range(1, 0) == 0) ? 0 : int'($urandom_range(255, MAX_WORDS + 1));
                frm = '{8'(n)};
            end else begin
                n = int'($urandom_range(10, 1));
                build_frame(n, ($urandom_range(3, 0) != 0));
            end
            send_frame("random", int'($urandom_range(2, 0)));
            if ($urandom_range(1, 0) == 1) send_junk("random_junk", int'($urandom_range(6, 1)));
        end

        // Asynchronous reset in the middle of DATA
        do_reload(1'b0, 8'h00);
        frm = '{8'h02, 8'h93, 8'h05, 8'h00, 8'h40, 8'h93, 8'h85};
        send_frame("pre_async", 0);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_im_we", 32'(bus.im_we), 32'd0);
        check("async_im_addr", 32'(bus.im_addr), 32'd0);
        check("async_im_wdata", bus.im_wdata, 32'd0);
        exp_run = 1'b0;
        exp_err = 1'b0;
        check_outputs("async");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        load_nominal(8'h85);
        send_frame("after_async", 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/im_boot_loader.md
# im_boot_loader

Loads the instruction memory from the UART receive stream at power-up and holds the RISC-V core in reset until a complete, checksum-verified program is in place. It sits between the UART RX byte interface and the instruction-memory write port, and drives the core's reset. It replaces the fixed ROM initial contents as the source of the program, so a new program can be run without resynthesis.

## Interface
Parameters:
- ADDR_W, 16, width of im_addr (matches pc width)
- MAX_WORDS, 64, maximum program length in 32-bit words (256-entry ROM, word-aligned byte addressing)

Ports:
- clk  in  1  system clock; one clock domain
- rst_n  in  1  asynchronous, active-low reset
- rx_valid  in  1  one-cycle strobe: rx_data holds a received byte
- rx_data  in  8  received byte
- reload  in  1  one-cycle pulse: abort or finish the current program and reload
- im_we  out  1  instruction-memory write enable, one cycle per word
- im_addr  out  ADDR_W  byte address of the word being written (4*index)
- im_wdata  out  32  word to write
- cpu_rst_n  out  1  core reset, active-low; low while loading
- busy  out  1  high in LEN, DATA and CHK
- err  out  1  high in ERR

## Operation
- Frame format: byte N (word count), then 4*N data bytes (each word little-endian), then 1 checksum byte equal to the XOR of all 4*N data bytes.
- The FSM has five states: LEN, DATA, CHK, RUN, ERR.
- LEN: on rx_valid, latch N. If N==0 or N>MAX_WORDS, go to ERR. Otherwise clear the word index, byte counter and XOR accumulator, then go to DATA.
- DATA: on each rx_valid:
  - shift rx_data into byte lane (byte counter);
  - XOR rx_data into the accumulator.
  - On the 4th byte, issue a write (im_addr=4*index, im_wdata=assembled word) and increment index.
  - After word N-1 is written, go to CHK.
- CHK: on rx_valid, if rx_data==accumulator go to RUN, else go to ERR.
- RUN: cpu_rst_n=1. rx_valid is ignored, because the UART belongs to the core.
- ERR: cpu_rst_n stays 0 and rx_valid is ignored. Words already written are not rolled back.
- reload in any state: next state is LEN; index, byte counter and accumulator are cleared; any partial word is discarded; cpu_rst_n=0. reload takes priority over a simultaneous rx_valid, and that byte is dropped.
- Index arithmetic: 7-bit counter. im_addr = {index,2'b00} zero-extended to ADDR_W. The maximum address is 4*(MAX_WORDS-1)=252.

## Timing
- Reset values: state=LEN, im_we=0, im_addr=0, im_wdata=0, cpu_rst_n=0, busy=1, err=0.
- All outputs are registered.
- im_we is high for exactly one cycle, in the cycle after the clock edge that accepted the 4th byte of a word. im_addr and im_wdata are valid in that same cycle and hold afterwards.
- Back-to-back rx_valid (every cycle) must be accepted without loss. No backpressure exists.
- cpu_rst_n rises in the cycle after the edge that accepted a matching checksum byte. busy falls in the same cycle.
- err rises in the cycle after the edge that accepted the bad N or the bad checksum.
- After reload, cpu_rst_n=0, busy=1 and err=0 from the next cycle.
- Asynchronous rst_n assertion mid-frame forces the reset values immediately, independent of clk. Loading restarts in LEN after deassertion.

## Test plan
- Nominal load: send 02, 93 05 00 40, 93 85 05 40, 85.
  - Expect im_we at addr 0x0000 with data 0x40000593, then at addr 0x0004 with data 0x40058593.
  - Then cpu_rst_n=1, busy=0, err=0.
  - Further rx_valid produces no im_we.
- Bad length: send 00.
  - Expect err=1 and cpu_rst_n=0, with no im_we.
  - Repeat with 41 (65) at MAX_WORDS=64; same response.
- Bad checksum: the nominal frame with checksum 84.
  - Expect both writes to occur, then err=1 and cpu_rst_n stays 0.
  - Then pulse reload and send the nominal frame; expect RUN.
- Reload mid-word: send 02, 93 05, then reload, then the nominal frame.
  - Expect first im_we at addr 0 with data 0x40000593; the partial bytes are discarded.
  - Also assert reload and rx_valid in the same cycle; the byte is dropped.
- Boundary and throughput: N=64, bytes streamed with rx_valid high every cycle.
  - Expect 64 writes, the last at addr 252.
  - Each im_we must come exactly 1 cycle after its 4th byte; then RUN.
- Async reset: drop rst_n between clock edges during DATA.
  - Outputs take their reset values immediately.
  - After release, a full nominal frame loads correctly from addr 0.
